hall_call_queue: RTL and testbench
==================================

Name: hall_call_queue

Overview:
- Upstream stage of the building controller; owns every hallway call button in the shaft.
- Synchronizes the raw up/down button inputs and latches each press as a pending call that also lights its hall lamp.
- Offers pending calls one at a time to the building controller over a valid/ack handshake, using a fair rotating scan.
- Clears each call and its lamp when a car reports that the floor/direction has been serviced.

Parameters:
- FLOOR_COUNT, 7, number of floors; floor indices 0..FLOOR_COUNT-1.
- FLOOR_BITS, 3, width of the floor field; must satisfy 2**FLOOR_BITS >= FLOOR_COUNT.
- DEBOUNCE_CYCLES, 16, stable-high cycles required per press; used only with HALL_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- hall_up_btn  input  FLOOR_COUNT  raw up buttons, asynchronous; bit FLOOR_COUNT-1 is ignored.
- hall_dn_btn  input  FLOOR_COUNT  raw down buttons, asynchronous; bit 0 is ignored.
- request_ack  input  1  building controller accepts the offered call.
- serviced_valid  input  1  a car has serviced a call, 1-cycle pulse.
- serviced_floor  input  FLOOR_BITS  floor that was serviced.
- serviced_up_ndown  input  1  direction that was serviced: 1 = up, 0 = down.
- hall_valid  output  1  hall_request holds a valid call.
- hall_request  output  FLOOR_BITS+1  call format: bit FLOOR_BITS = up_ndown, low bits = floor.
- hall_up_lamp  output  FLOOR_COUNT  up-call lamps; bit FLOOR_COUNT-1 is always 0.
- hall_dn_lamp  output  FLOOR_COUNT  down-call lamps; bit 0 is always 0.

Behaviour:
Reset:
- Asserting reset at any time, including mid-handshake, clears asynchronously: all pending and dispatched bits, lamps, synchronizers, scan pointer, hall_valid and hall_request. FSM returns to SCAN.

Input capture:
- Each button passes through a 2-flop synchronizer, then a rising-edge detector.
- A detected edge sets pending[i]. Pending is set on the 3rd rising clk edge after the button goes high.
- Lamp = pending. A button held high, or a re-press of an already-pending call, has no further effect.

Call indexing:
- Up calls use index = floor (0..FLOOR_COUNT-1).
- Down calls use index = FLOOR_COUNT + floor.
- Ignored button bits never become pending.

FSM states:
- SCAN:
  - Search pending & ~dispatched, starting at scan_ptr and wrapping modulo 2*FLOOR_COUNT.
  - If a candidate is found: register it into hall_request, set hall_valid=1 and go to OFFER. hall_valid rises 1 cycle after entering SCAN with a candidate present.
  - If no candidate: stay in SCAN with hall_valid=0.
- OFFER:
  - hall_request is held stable while hall_valid=1.
  - On request_ack=1: set dispatched for the offered index, set scan_ptr = index+1 (wrapping), set hall_valid=0 the same edge, and go to SCAN.
  - request_ack is ignored while in SCAN.

Service clear:
- When serviced_valid=1, clear pending and dispatched for the matching index; the lamp goes off on the next edge.
- If that index is the one being offered and not acked the same cycle: withdraw it (hall_valid=0), go to SCAN, leave scan_ptr unchanged.

Simultaneous events on the same index:
- Service clear and new press edge: the press wins; pending=1, dispatched=0.
- Service clear and ack: the clear wins; pending=0, dispatched=0.
- Service clear of an index that is not pending: no effect.

Out-of-range or ignored service:
- serviced_floor >= FLOOR_COUNT is ignored.
- A service for an ignored direction bit (up at the top floor, down at floor 0) is ignored.

Optional Feature:
- Macro: HALL_DEBOUNCE_EN.
- Defined: a per-button counter requires the synchronized level to be high for DEBOUNCE_CYCLES consecutive cycles before an edge is accepted. Any low sample resets the counter. Pending is set DEBOUNCE_CYCLES+2 edges after a clean press; a glitch shorter than DEBOUNCE_CYCLES produces no call.
- Undefined: no counters; the timing is as described under Input capture.

Test Plan:
- Reset, then pulse hall_up_btn[2] for 4 cycles -> hall_up_lamp[2]=1 on the 3rd edge; hall_valid=1 with hall_request=4'b1_010; hold 5 cycles with no ack -> hall_request stays stable.
- Pending calls up 1 and down 5; ack each offer -> offered order 4'b1_001 then 4'b0_101; after both acks hall_valid=0 and lamps remain lit.
- Dispatched up 3, then serviced_valid with floor=3, up_ndown=1 -> hall_up_lamp[3]=0 next cycle; a fresh press relights it and it is re-offered.
- Offering down 4; service floor 4 down with no ack -> hall_valid=0 next cycle; down 4 is never re-offered.
- Press hall_up_btn[6] and hall_dn_btn[0] -> no lamp and no hall_valid. Assert reset while hall_valid=1 -> all outputs 0 immediately, before the clk edge.
- With HALL_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle pulse produces no lamp; a 20-cycle pulse sets the lamp on edge 18.

Source files
------------

// File: rtl/hall_call_queue_if.sv
// Hall-call handshake bundle: call offer towards the building controller and the
// serviced-call report coming back from the cars.
interface hall_call_queue_if #(
    parameter int unsigned FLOOR_BITS = 3
);
    logic                  hall_valid;
    logic [FLOOR_BITS:0]   hall_request;
    logic                  request_ack;
    logic                  serviced_valid;
    logic [FLOOR_BITS-1:0] serviced_floor;
    logic                  serviced_up_ndown;

    modport master (
        output hall_valid,
        output hall_request,
        input  request_ack,
        input  serviced_valid,
        input  serviced_floor,
        input  serviced_up_ndown
    );

    modport slave (
        input  hall_valid,
        input  hall_request,
        output request_ack,
        output serviced_valid,
        output serviced_floor,
        output serviced_up_ndown
    );
endinterface

// File: rtl/hall_call_queue.sv
// Latches hall button presses as pending calls (lamps) and offers them one at a time with a
// rotating fair scan. Define HALL_DEBOUNCE_EN to add per-button stable-high debounce counters.
module hall_call_queue #(
    parameter int unsigned FLOOR_COUNT     = 7,
    parameter int unsigned FLOOR_BITS      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLOOR_COUNT-1:0] hall_up_btn,
    input  logic [FLOOR_COUNT-1:0] hall_dn_btn,
    hall_call_queue_if.master      bus,
    output logic [FLOOR_COUNT-1:0] hall_up_lamp,
    output logic [FLOOR_COUNT-1:0] hall_dn_lamp
);
    // Up calls occupy indices 0..FLOOR_COUNT-1, down calls FLOOR_COUNT..2*FLOOR_COUNT-1.
    localparam int unsigned NUM_CALLS = 2 * FLOOR_COUNT;
    localparam int unsigned IDX_BITS  = $clog2(NUM_CALLS);

    if ((2 ** FLOOR_BITS) < FLOOR_COUNT) begin : g_bad_floor_bits
        $error("FLOOR_BITS too narrow for FLOOR_COUNT");
    end
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be non-zero");
    end

    typedef enum logic [0:0] {StScan, StOffer} state_e;

    state_e                  state_q, state_d;
    logic [NUM_CALLS-1:0]    call_mask;
    logic [NUM_CALLS-1:0]    sync1_q, sync2_q;
    logic [NUM_CALLS-1:0]    press;
    logic [NUM_CALLS-1:0]    pending_q, pending_d;
    logic [NUM_CALLS-1:0]    dispatched_q, dispatched_d;
    logic [NUM_CALLS-1:0]    clear_mask, ack_mask, avail;
    logic [IDX_BITS-1:0]     scan_ptr_q, scan_ptr_d;
    logic [IDX_BITS-1:0]     offer_q, offer_d;
    logic [IDX_BITS-1:0]     svc_idx, cand_idx;
    logic                    svc_hit, cand_found;
    logic                    valid_q, valid_d;
    logic [FLOOR_BITS:0]     request_q, request_d;

    // Up at the top floor and down at floor 0 do not exist.
    always_comb begin
        call_mask                  = '1;
        call_mask[FLOOR_COUNT-1]   = 1'b0;
        call_mask[FLOOR_COUNT]     = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {hall_dn_btn, hall_up_btn};
            sync2_q <= sync1_q;
        end
    end

`ifdef HALL_DEBOUNCE_EN
    localparam int unsigned CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_BITS-1:0] cnt_q [NUM_CALLS];
    logic [CNT_BITS-1:0] cnt_d [NUM_CALLS];

    // Counter saturates at DEBOUNCE_CYCLES so a held button yields exactly one press.
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < NUM_CALLS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!sync2_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_BITS'(DEBOUNCE_CYCLES)) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end
            press[i] = sync2_q[i] && (cnt_q[i] == CNT_BITS'(DEBOUNCE_CYCLES - 1)) && call_mask[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CALLS; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CALLS; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic [NUM_CALLS-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= '0;
        else       prev_q <= sync2_q;
    end

    assign press = sync2_q & ~prev_q & call_mask;
`endif

    always_comb begin
        svc_hit    = 1'b0;
        svc_idx    = '0;
        clear_mask = '0;
        if (bus.serviced_valid && (32'(bus.serviced_floor) < FLOOR_COUNT)) begin
            svc_idx = bus.serviced_up_ndown ? IDX_BITS'(bus.serviced_floor)
                                            : IDX_BITS'(FLOOR_COUNT + 32'(bus.serviced_floor));
            svc_hit = call_mask[svc_idx];
        end
        if (svc_hit) clear_mask[svc_idx] = 1'b1;
    end

    // A call being cleared this cycle is not offered.
    always_comb begin
        int unsigned pos;
        pos        = 0;
        cand_found = 1'b0;
        cand_idx   = '0;
        avail      = pending_q & ~dispatched_q & ~clear_mask;
        for (int unsigned k = 0; k < NUM_CALLS; k++) begin
            pos = 32'(scan_ptr_q) + k;
            if (pos >= NUM_CALLS) pos = pos - NUM_CALLS;
            if (!cand_found && avail[pos]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_BITS'(pos);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        request_d  = request_q;
        offer_d    = offer_q;
        scan_ptr_d = scan_ptr_q;
        ack_mask   = '0;
        unique case (state_q)
            StScan: begin
                valid_d = 1'b0;
                if (cand_found) begin
                    offer_d = cand_idx;
                    valid_d = 1'b1;
                    state_d = StOffer;
                    if (32'(cand_idx) < FLOOR_COUNT) begin
                        request_d = {1'b1, FLOOR_BITS'(cand_idx)};
                    end else begin
                        request_d = {1'b0, FLOOR_BITS'(32'(cand_idx) - FLOOR_COUNT)};
                    end
                end
            end
            StOffer: begin
                if (bus.request_ack) begin
                    ack_mask[offer_q] = 1'b1;
                    scan_ptr_d = (offer_q == IDX_BITS'(NUM_CALLS - 1)) ? '0
                                                                        : offer_q + IDX_BITS'(1);
                    valid_d    = 1'b0;
                    state_d    = StScan;
                end else if (svc_hit && (svc_idx == offer_q)) begin
                    valid_d = 1'b0;
                    state_d = StScan;
                end
            end
            default: state_d = StScan;
        endcase
    end

    // A press beats a same-cycle clear; a clear beats a same-cycle ack.
    assign pending_d    = ((pending_q & ~clear_mask) | press) & call_mask;
    assign dispatched_d = (dispatched_q | ack_mask) & ~clear_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StScan;
            pending_q    <= '0;
            dispatched_q <= '0;
            scan_ptr_q   <= '0;
            offer_q      <= '0;
            valid_q      <= 1'b0;
            request_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            dispatched_q <= dispatched_d;
            scan_ptr_q   <= scan_ptr_d;
            offer_q      <= offer_d;
            valid_q      <= valid_d;
            request_q    <= request_d;
        end
    end

    assign hall_up_lamp     = pending_q[FLOOR_COUNT-1:0];
    assign hall_dn_lamp     = pending_q[NUM_CALLS-1:FLOOR_COUNT];
    assign bus.hall_valid   = valid_q;
    assign bus.hall_request = request_q;
endmodule

// File: tb/tb_hall_call_queue.sv
// Bench for hall_call_queue: hand vectors, directed corner sequences and a random run
// checked cycle-by-cycle against a call-list reference model.
module tb_hall_call_queue;
    localparam int N  = 7;
    localparam int FB = 3;
    localparam int NC = 2 * N;
`ifdef HALL_DEBOUNCE_EN
    localparam int DC_EFF = 16;
`else
    localparam int DC_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] up_btn, dn_btn, up_lamp, dn_lamp;

    hall_call_queue_if #(.FLOOR_BITS(FB)) bus ();

    hall_call_queue #(
        .FLOOR_COUNT    (N),
        .FLOOR_BITS     (FB),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hall_up_btn (up_btn),
        .hall_dn_btn (dn_btn),
        .bus         (bus),
        .hall_up_lamp(up_lamp),
        .hall_dn_lamp(dn_lamp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of call flags plus "which call is on offer".
    bit         m_pend[NC];
    bit         m_disp[NC];
    bit         m_h1[NC];
    int         m_run[NC];
    bit         m_offering;
    int         m_offer;
    int         m_ptr;
    bit         m_valid;
    logic [3:0] m_req;

    function automatic bit is_call(int i);
        return (i < N) ? (i != N - 1) : (i != N);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_pend[i] = 0; m_disp[i] = 0; m_h1[i] = 0; m_run[i] = 0;
        end
        m_offering = 0; m_offer = 0; m_ptr = 0; m_valid = 0; m_req = '0;
    endtask

    task automatic model_edge(input logic [6:0] up, input logic [6:0] dn, input logic ack,
                              input logic sv, input logic [2:0] sf, input logic sud);
        logic [13:0] btn;
        bit          press[NC];
        int          clr, cand, ack_idx, idx;
        btn  = {dn, up};
        clr  = -1;
        cand = -1;
        // A press is recognised when the delayed sample run of highs reaches DC_EFF.
        for (int i = 0; i < NC; i++) begin
            press[i] = is_call(i) && (m_run[i] == DC_EFF);
            if (!m_h1[i])                m_run[i] = 0;
            else if (m_run[i] <= DC_EFF) m_run[i] = m_run[i] + 1;
            m_h1[i] = btn[i];
        end
        if (sv && int'(sf) < N) begin
            idx = sud ? int'(sf) : N + int'(sf);
            if (is_call(idx)) clr = idx;
        end
        if (!m_offering) begin
            for (int k = 0; k < NC; k++) begin
                int j;
                j = (m_ptr + k) % NC;
                if (cand < 0 && m_pend[j] && !m_disp[j] && j != clr) cand = j;
            end
        end
        ack_idx = (m_offering && ack) ? m_offer : -1;
        for (int i = 0; i < NC; i++) begin
            m_pend[i] = (m_pend[i] && i != clr) || press[i];
            m_disp[i] = (m_disp[i] || i == ack_idx) && i != clr;
        end
        if (!m_offering) begin
            if (cand >= 0) begin
                m_offering = 1; m_offer = cand; m_valid = 1;
                m_req[3]   = (cand < N);
                m_req[2:0] = (cand < N) ? 3'(cand) : 3'(cand - N);
            end else begin
                m_valid = 0;
            end
        end else if (ack) begin
            m_ptr = (m_offer + 1) % NC; m_offering = 0; m_valid = 0;
        end else if (clr == m_offer) begin
            m_offering = 0; m_valid = 0;
        end
    endtask

    function automatic logic [6:0] m_lamp(int base);
        logic [6:0] r;
        for (int i = 0; i < N; i++) r[i] = m_pend[base + i];
        return r;
    endfunction

    task automatic step(input logic [6:0] up, input logic [6:0] dn, input logic ack,
                        input logic sv, input logic [2:0] sf, input logic sud);
        up_btn = up; dn_btn = dn;
        bus.request_ack = ack; bus.serviced_valid = sv;
        bus.serviced_floor = sf; bus.serviced_up_ndown = sud;
        @(posedge clk);
        model_edge(up, dn, ack, sv, sf, sud);
        #1;
        check("model_valid", 32'(bus.hall_valid), 32'(m_valid));
        if (m_valid) check("model_request", 32'(bus.hall_request), 32'(m_req));
        check("model_up_lamp", 32'(up_lamp), 32'(m_lamp(0)));
        check("model_dn_lamp", 32'(dn_lamp), 32'(m_lamp(N)));
    endtask

    task automatic idle();
        step('0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic press(input logic [6:0] up, input logic [6:0] dn);
        for (int i = 0; i < DC_EFF + 2; i++) step(up, dn, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        up_btn = '0; dn_btn = '0;
        bus.request_ack = 0; bus.serviced_valid = 0;
        bus.serviced_floor = '0; bus.serviced_up_ndown = 0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max, input string name, output logic [3:0] req);
        bit ok;
        ok  = 0;
        req = '0;
        for (int i = 0; i < max && !ok; i++) begin
            idle();
            if (bus.hall_valid) begin
                ok  = 1;
                req = bus.hall_request;
            end
        end
        if (!ok) check(name, 32'(0), 32'(1));
    endtask

    typedef struct {
        logic [6:0] up;
        logic [6:0] dn;
        logic       ack;
        logic       sv;
        logic [2:0] sf;
        logic       sud;
        logic       ev;
        logic [3:0] ereq;
        logic [6:0] eup;
        logic [6:0] edn;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [3:0] req;
        logic [6:0] cur_up, cur_dn;
        bit         saw;

        do_reset();
        check("reset_valid", 32'(bus.hall_valid), 32'(0));
        check("reset_request", 32'(bus.hall_request), 32'(0));
        check("reset_up_lamp", 32'(up_lamp), 32'(0));
        check("reset_dn_lamp", 32'(dn_lamp), 32'(0));

`ifndef HALL_DEBOUNCE_EN
        // 4-cycle press of up 2, held offer, ack, then service clear.
        tbl[0]  = '{7'b0000100, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 7'b0000000, 7'b0};
        tbl[1]  = '{7'b0000100, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 7'b0000000, 7'b0};
        tbl[2]  = '{7'b0000100, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 7'b0000100, 7'b0};
        tbl[3]  = '{7'b0000100, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'hA, 7'b0000100, 7'b0};
        tbl[4]  = '{7'b0000000, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'hA, 7'b0000100, 7'b0};
        tbl[5]  = '{7'b0000000, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'hA, 7'b0000100, 7'b0};
        tbl[6]  = '{7'b0000000, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'hA, 7'b0000100, 7'b0};
        tbl[7]  = '{7'b0000000, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'hA, 7'b0000100, 7'b0};
        tbl[8]  = '{7'b0000000, 7'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 7'b0000100, 7'b0};
        tbl[9]  = '{7'b0000000, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 7'b0000100, 7'b0};
        tbl[10] = '{7'b0000000, 7'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 4'h0, 7'b0000000, 7'b0};
        tbl[11] = '{7'b0000000, 7'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 7'b0000000, 7'b0};
        for (int r = 0; r < 12; r++) begin
            step(tbl[r].up, tbl[r].dn, tbl[r].ack, tbl[r].sv, tbl[r].sf, tbl[r].sud);
            check($sformatf("tbl%0d_valid", r), 32'(bus.hall_valid), 32'(tbl[r].ev));
            if (tbl[r].ev) check($sformatf("tbl%0d_request", r), 32'(bus.hall_request),
                                 32'(tbl[r].ereq));
            check($sformatf("tbl%0d_up_lamp", r), 32'(up_lamp), 32'(tbl[r].eup));
            check($sformatf("tbl%0d_dn_lamp", r), 32'(dn_lamp), 32'(tbl[r].edn));
        end
`endif

        // Fair order: up 1 then down 5, lamps stay lit after dispatch.
        do_reset();
        press(7'b0000010, 7'b0100000);
        wait_valid(40, "order_first_timeout", req);
        check("order_first", 32'(req), 32'(4'b1001));
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0);
        wait_valid(10, "order_second_timeout", req);
        check("order_second", 32'(req), 32'(4'b0101));
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        check("order_idle_valid", 32'(bus.hall_valid), 32'(0));
        check("order_up_lamp", 32'(up_lamp), 32'(7'b0000010));
        check("order_dn_lamp", 32'(dn_lamp), 32'(7'b0100000));

        // Dispatched up 3 serviced, then pressed again and re-offered.
        do_reset();
        press(7'b0001000, '0);
        wait_valid(40, "svc_offer_timeout", req);
        check("svc_offer", 32'(req), 32'(4'b1011));
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0);
        step('0, '0, 1'b0, 1'b1, 3'd3, 1'b1);
        check("svc_lamp_off", 32'(up_lamp[3]), 32'(0));
        press(7'b0001000, '0);
        wait_valid(40, "svc_reoffer_timeout", req);
        check("svc_reoffer", 32'(req), 32'(4'b1011));

        // Withdraw an unacked offer of down 4.
        do_reset();
        press('0, 7'b0010000);
        wait_valid(40, "wd_offer_timeout", req);
        check("wd_offer", 32'(req), 32'(4'b0100));
        step('0, '0, 1'b0, 1'b1, 3'd4, 1'b0);
        check("wd_valid_drop", 32'(bus.hall_valid), 32'(0));
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            if (bus.hall_valid) saw = 1;
        end
        check("wd_never_reoffered", 32'(saw), 32'(0));
        check("wd_dn_lamp", 32'(dn_lamp), 32'(0));

        // Nonexistent buttons: up at top floor, down at floor 0.
        do_reset();
        press(7'b1000000, 7'b0000001);
        for (int i = 0; i < 6; i++) idle();
        check("ign_up_lamp", 32'(up_lamp), 32'(0));
        check("ign_dn_lamp", 32'(dn_lamp), 32'(0));
        check("ign_valid", 32'(bus.hall_valid), 32'(0));

        // Asynchronous reset while an offer is up.
        do_reset();
        press(7'b0000100, 7'b0001000);
        wait_valid(40, "areset_offer_timeout", req);
        #1;
        reset = 1'b1;
        #1;
        check("areset_valid", 32'(bus.hall_valid), 32'(0));
        check("areset_request", 32'(bus.hall_request), 32'(0));
        check("areset_up_lamp", 32'(up_lamp), 32'(0));
        check("areset_dn_lamp", 32'(dn_lamp), 32'(0));
        do_reset();

`ifdef HALL_DEBOUNCE_EN
        for (int i = 0; i < 10; i++) step(7'b0000100, '0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) idle();
        check("db_glitch_lamp", 32'(up_lamp), 32'(0));
        for (int e = 1; e <= 20; e++) begin
            step(7'b0000100, '0, 1'b0, 1'b0, 3'd0, 1'b0);
            if (e == 17) check("db_edge17_lamp", 32'(up_lamp[2]), 32'(0));
            if (e == 18) check("db_edge18_lamp", 32'(up_lamp[2]), 32'(1));
        end
        do_reset();
`endif

        // Random traffic against the model.
        cur_up = '0;
        cur_dn = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                cur_up = '0;
                cur_dn = '0;
            end
            cur_up ^= 7'($urandom) & 7'($urandom) & 7'($urandom);
            cur_dn ^= 7'($urandom) & 7'($urandom) & 7'($urandom);
            step(cur_up, cur_dn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
